sha2_padder: RTL and testbench

SHA2_PADDER -- requirements
Module: sha2_padder

---
 rtl/sha2_padder.sv | 192 +++++++++++++++++++
 tb/tb_sha2_padder.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_padder.sv
// SHA-2 message padder: packs 64-bit AXIS words into 512-bit beats and appends 0x80, zero fill and length.
// Codec is the varint in s_axis_tuser[15:0], first varint byte in [15:8]; SHA2-384/512 select 1024-bit blocks.
module sha2_padder #(
  parameter int C_S_AXIS_DATA_WIDTH = 64,
  parameter int C_M_AXIS_DATA_WIDTH = 512,
  parameter int C_AXIS_TUSER_WIDTH  = 128
) (
  input  logic                             axis_aclk,
  input  logic                             axis_resetn,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TUSER_WIDTH-1:0]    m_axis_tuser,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic                             m_axis_tlast
);

  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, FILL, PAD, EXTRA, HOLD} state_t;

  state_t                           state;
  state_t                           next_after;
  logic [C_M_AXIS_DATA_WIDTH-1:0]   beat;
  logic [60:0]                      byte_cnt;
  logic [2:0]                       word_idx;
  logic [6:0]                       pad_pos;
  logic                             mode_1024;
  logic                             half;
  logic                             first;
  logic                             pend_80;
  logic [C_S_AXIS_DATA_WIDTH-1:0]   s_word;
  logic [3:0]                       keep_cnt;
  logic [63:0]                      bit_len;
  logic [63:0]                      len_be;
  logic                             final_beat;

  // Varint codec decode; anything that is not SHA2-384/512 falls back to 512-bit mode.
  function automatic logic is_wide(input logic [15:0] field);
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [13:0] code;
    b0 = field[15:8];
    b1 = field[7:0];
    if (!b0[7])
      code = {7'd0, b0[6:0]};
    else if (!b1[7])
      code = {b1[6:0], b0[6:0]};
    else
      code = 14'h3FFF;
    return (code == 14'h0013) || (code == 14'h0020);
  endfunction

  always_comb begin
    s_word   = '0;
    keep_cnt = '0;
    for (int k = 0; k < KEEP_W; k++) begin
      if (s_axis_tkeep[k]) begin
        s_word[8*k +: 8] = s_axis_tdata[8*k +: 8];
        keep_cnt         = keep_cnt + 4'd1;
      end
    end
  end

  // Bit count is big-endian in beat bytes 56..63 of every final beat, in both modes.
  assign bit_len = {byte_cnt, 3'b000};

  always_comb begin
    len_be = '0;
    for (int k = 0; k < 8; k++)
      len_be[8*k +: 8] = bit_len[8*(7-k) +: 8];
  end

  assign final_beat    = !mode_1024 || half;
  assign s_axis_tready = (state == FILL);
  assign m_axis_tdata  = beat;

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state         <= IDLE;
      next_after    <= IDLE;
      beat          <= '0;
      byte_cnt      <= '0;
      word_idx      <= '0;
      pad_pos       <= '0;
      mode_1024     <= 1'b0;
      half          <= 1'b0;
      first         <= 1'b1;
      pend_80       <= 1'b0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          beat     <= '0;
          byte_cnt <= '0;
          word_idx <= '0;
          half     <= 1'b0;
          pend_80  <= 1'b0;
          first    <= 1'b1;
          if (s_axis_tvalid)
            state <= FILL;
        end

        FILL: begin
          if (s_axis_tvalid) begin
            beat[{word_idx, 6'd0} +: 64] <= s_word;
            byte_cnt <= byte_cnt + 61'(keep_cnt);
            if (first) begin
              first        <= 1'b0;
              m_axis_tuser <= s_axis_tuser;
              mode_1024    <= is_wide(s_axis_tuser[15:0]);
            end
            if (s_axis_tlast) begin
              pad_pos  <= 7'({word_idx, 3'b000}) + 7'(keep_cnt);
              word_idx <= '0;
              state    <= PAD;
            end else if (word_idx == 3'd7) begin
              word_idx      <= '0;
              m_axis_tvalid <= 1'b1;
              m_axis_tlast  <= 1'b0;
              next_after    <= FILL;
              state         <= HOLD;
            end else begin
              word_idx <= word_idx + 3'd1;
            end
          end
        end

        // A full last word leaves no room, so the 0x80 moves to byte 0 of the next beat.
        PAD: begin
          m_axis_tvalid <= 1'b1;
          state         <= HOLD;
          if (pad_pos[6]) begin
            pend_80      <= 1'b1;
            m_axis_tlast <= 1'b0;
            next_after   <= EXTRA;
          end else begin
            beat[{pad_pos[5:0], 3'b000} +: 8] <= 8'h80;
            if (final_beat && (pad_pos <= (mode_1024 ? 7'd47 : 7'd55))) begin
              beat[511:448] <= len_be;
              m_axis_tlast  <= 1'b1;
              next_after    <= IDLE;
            end else begin
              m_axis_tlast <= 1'b0;
              next_after   <= EXTRA;
            end
          end
        end

        EXTRA: begin
          beat <= '0;
          if (pend_80)
            beat[7:0] <= 8'h80;
          pend_80       <= 1'b0;
          m_axis_tvalid <= 1'b1;
          state         <= HOLD;
          if (final_beat) begin
            beat[511:448] <= len_be;
            m_axis_tlast  <= 1'b1;
            next_after    <= IDLE;
          end else begin
            m_axis_tlast <= 1'b0;
            next_after   <= EXTRA;
          end
        end

        HOLD: begin
          if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            beat          <= '0;
            if (mode_1024)
              half <= ~half;
            if (next_after == IDLE)
              byte_cnt <= '0;
            state <= next_after;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_padder.sv
// Directed testbench for sha2_padder: hand-computed padded beats for SHA2-256/384/512 messages.
module tb_sha2_padder;

  logic         axis_aclk = 1'b0;
  logic         axis_resetn = 1'b0;
  logic [63:0]  s_axis_tdata = '0;
  logic [7:0]   s_axis_tkeep = '0;
  logic [127:0] s_axis_tuser = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;
  logic [511:0] m_axis_tdata;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] USER_256 = 128'h0123_4567_89AB_CDEF_0000_0000_0000_1200;
  localparam logic [127:0] USER_512 = 128'hFEDC_BA98_7654_3210_0000_0000_0000_1300;
  localparam logic [127:0] USER_384 = 128'h1111_2222_3333_4444_0000_0000_0000_2000;
  localparam logic [127:0] USER_BAD = 128'hA5A5_A5A5_0000_0000_0000_0000_0000_5500;

  sha2_padder dut (
    .axis_aclk     (axis_aclk),
    .axis_resetn   (axis_resetn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
  );

  always #5 axis_aclk = ~axis_aclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, wanted completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Message byte i carries the value i+1.
  function automatic logic [63:0] pat_word(input int w);
    logic [63:0] r;
    for (int k = 0; k < 8; k++) r[8*k +: 8] = 8'(w*8 + k + 1);
    return r;
  endfunction

  function automatic logic [511:0] pat_beat(input int first_byte, input int nbytes);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < nbytes; i++) r[8*i +: 8] = 8'(first_byte + i + 1);
    return r;
  endfunction

  task automatic send_word(input logic [63:0] data, input logic [7:0] keep,
                           input logic last, input logic [127:0] user);
    bit accepted;
    accepted      = 1'b0;
    s_axis_tdata  = data;
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    s_axis_tuser  = user;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge axis_aclk);
      if (s_axis_tready) accepted = 1'b1;
      @(posedge axis_aclk);
    end
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tkeep  = '0;
    checks++;
    if (!accepted) begin
      errors++;
      $display("[TB] FAIL send_timeout: s_axis_tready got 0, wanted 1");
    end
  endtask

  task automatic recv_beat(output logic [511:0] data, output logic last, output logic [127:0] user);
    bit seen;
    seen = 1'b0;
    data = '0;
    last = 1'b0;
    user = '0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge axis_aclk);
      if (m_axis_tvalid) begin
        seen = 1'b1;
        data = m_axis_tdata;
        last = m_axis_tlast;
        user = m_axis_tuser;
      end
    end
    if (seen) begin
      m_axis_tready = 1'b1;
      @(posedge axis_aclk);
      #1;
      m_axis_tready = 1'b0;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL recv_timeout: m_axis_tvalid got 0, wanted 1");
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge axis_aclk);
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b, wanted 000", {s_axis_tready, m_axis_tvalid, m_axis_tlast});
    end
    checks++;
    if (m_axis_tdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_tdata: got %h, wanted 0", m_axis_tdata);
    end
    checks++;
    if (m_axis_tuser !== '0) begin
      errors++;
      $display("[TB] FAIL reset_tuser: got %h, wanted 0", m_axis_tuser);
    end
    axis_resetn = 1'b1;
    repeat (2) @(negedge axis_aclk);
    checks++;
    if ({s_axis_tready, m_axis_tvalid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL idle_ctrl: got %b, wanted 00", {s_axis_tready, m_axis_tvalid});
    end
  endtask

  task automatic test_abc_256(input logic [127:0] user);
    logic [511:0] d, exp;
    logic         l;
    logic [127:0] u;
    send_word(64'h0000_0000_0063_6261, 8'h07, 1'b1, user);
    recv_beat(d, l, u);
    exp = '0;
    exp[23:0]    = 24'h63_6261;
    exp[31:24]   = 8'h80;
    exp[511:504] = 8'h18;
    checks++;
    if (d !== exp) begin
      errors++;
      $display("[TB] FAIL abc256_data: got %h, wanted %h", d, exp);
    end
    checks++;
    if (l !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abc256_last: got %b, wanted 1", l);
    end
    checks++;
    if (u !== user) begin
      errors++;
      $display("[TB] FAIL abc256_user: got %h, wanted %h", u, user);
    end
    repeat (4) @(negedge axis_aclk);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abc256_extra_beat: tvalid got %b, wanted 0", m_axis_tvalid);
    end
  endtask

  task automatic test_56_byte();
    logic [511:0] d, exp;
    logic         l;
    logic [127:0] u;
    for (int w = 0; w < 7; w++) send_word(pat_word(w), 8'hFF, (w == 6), USER_256);
    recv_beat(d, l, u);
    exp = pat_beat(0, 56);
    exp[455:448] = 8'h80;
    checks++;
    if (d !== exp || l !== 1'b0) begin
      errors++;
      $display("[TB] FAIL len56_beat1: got %h last %b, wanted %h last 0", d, l, exp);
    end
    recv_beat(d, l, u);
    exp = '0;
    exp[503:496] = 8'h01;
    exp[511:504] = 8'hC0;
    checks++;
    if (d !== exp || l !== 1'b1) begin
      errors++;
      $display("[TB] FAIL len56_beat2: got %h last %b, wanted %h last 1", d, l, exp);
    end
  endtask

  task automatic test_abc_512();
    logic [511:0] d, exp;
    logic         l;
    logic [127:0] u;
    send_word(64'h0000_0000_0063_6261, 8'h07, 1'b1, USER_512);
    recv_beat(d, l, u);
    exp = '0;
    exp[31:0] = 32'h8063_6261;
    checks++;
    if (d !== exp || l !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abc512_left: got %h last %b, wanted %h last 0", d, l, exp);
    end
    checks++;
    if (u !== USER_512) begin
      errors++;
      $display("[TB] FAIL abc512_user: got %h, wanted %h", u, USER_512);
    end
    recv_beat(d, l, u);
    exp = '0;
    exp[511:504] = 8'h18;
    checks++;
    if (d !== exp || l !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abc512_right: got %h last %b, wanted %h last 1", d, l, exp);
    end
  endtask

  task automatic test_empty();
    logic [511:0] d, exp;
    logic         l;
    logic [127:0] u;
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b1, USER_256);
    recv_beat(d, l, u);
    exp = '0;
    exp[7:0] = 8'h80;
    checks++;
    if (d !== exp || l !== 1'b1) begin
      errors++;
      $display("[TB] FAIL empty_beat: got %h last %b, wanted %h last 1", d, l, exp);
    end
    repeat (4) @(negedge axis_aclk);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL empty_extra_beat: tvalid got %b, wanted 0", m_axis_tvalid);
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] d, exp, held;
    logic         l;
    logic [127:0] u;
    for (int w = 0; w < 8; w++) send_word(pat_word(w), 8'hFF, (w == 7), USER_256);
    for (int i = 0; i < 50 && !m_axis_tvalid; i++) @(negedge axis_aclk);
    checks++;
    if (m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_valid_timeout: tvalid got %b, wanted 1", m_axis_tvalid);
    end
    held = m_axis_tdata;
    for (int i = 0; i < 5; i++) begin
      @(negedge axis_aclk);
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held || s_axis_tready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold: tvalid %b s_tready %b data_changed %b, wanted 1 0 0",
                 m_axis_tvalid, s_axis_tready, (m_axis_tdata !== held));
      end
    end
    recv_beat(d, l, u);
    exp = pat_beat(0, 64);
    checks++;
    if (d !== exp || l !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_beat1: got %h last %b, wanted %h last 0", d, l, exp);
    end
    recv_beat(d, l, u);
    exp = '0;
    exp[7:0]     = 8'h80;
    exp[503:496] = 8'h02;
    checks++;
    if (d !== exp || l !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_beat2: got %h last %b, wanted %h last 1", d, l, exp);
    end
    repeat (4) @(negedge axis_aclk);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_extra_beat: tvalid got %b, wanted 0", m_axis_tvalid);
    end
  endtask

  task automatic test_sha384_70();
    logic [511:0] d0, d1, exp;
    logic         l0, l1;
    logic [127:0] u0, u1;
    fork
      begin
        for (int w = 0; w < 8; w++) send_word(pat_word(w), 8'hFF, 1'b0, USER_384);
        send_word(pat_word(8), 8'h3F, 1'b1, USER_384);
      end
      begin
        recv_beat(d0, l0, u0);
        recv_beat(d1, l1, u1);
      end
    join
    exp = pat_beat(0, 64);
    checks++;
    if (d0 !== exp || l0 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sha384_left: got %h last %b, wanted %h last 0", d0, l0, exp);
    end
    exp = pat_beat(64, 6);
    exp[55:48]   = 8'h80;
    exp[503:496] = 8'h02;
    exp[511:504] = 8'h30;
    checks++;
    if (d1 !== exp || l1 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL sha384_right: got %h last %b, wanted %h last 1", d1, l1, exp);
    end
    checks++;
    if (u1 !== USER_384) begin
      errors++;
      $display("[TB] FAIL sha384_user: got %h, wanted %h", u1, USER_384);
    end
  endtask

  task automatic test_reset_mid();
    for (int w = 0; w < 3; w++) send_word(pat_word(w), 8'hFF, 1'b0, USER_512);
    @(negedge axis_aclk);
    axis_resetn = 1'b0;
    #1;
    checks++;
    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL midreset_ctrl: got %b, wanted 000", {s_axis_tready, m_axis_tvalid, m_axis_tlast});
    end
    checks++;
    if (m_axis_tdata !== '0 || m_axis_tuser !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_data: tdata %h tuser %h, wanted 0", m_axis_tdata, m_axis_tuser);
    end
    @(negedge axis_aclk);
    axis_resetn = 1'b1;
    @(negedge axis_aclk);
    test_abc_256(USER_256);
  endtask

  initial begin
    test_reset();
    test_abc_256(USER_256);
    test_56_byte();
    test_abc_512();
    test_empty();
    test_backpressure();
    test_sha384_70();
    test_abc_256(USER_BAD);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
